// File: rtl/terminal_writer_if.sv
// terminal_writer_if: byte-stream handshake and character-plane write bus
// between a byte source and terminal_writer.
interface terminal_writer_if;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic [7:0] wr_character_id;
   logic [3:0] wr_row;
   logic [5:0] wr_column;
   logic       we;
   logic       push_up;
   logic [3:0] cursor_row;
   logic [5:0] cursor_column;

   modport master (
      output char_in, char_valid,
      input  char_ready, wr_character_id, wr_row, wr_column, we, push_up,
             cursor_row, cursor_column
   );

   modport slave (
      input  char_in, char_valid,
      output char_ready, wr_character_id, wr_row, wr_column, we, push_up,
             cursor_row, cursor_column
   );
endinterface

// File: rtl/terminal_writer.sv
// terminal_writer: turns a byte stream into character-plane write strobes,
// tracks the text cursor, scrolls the plane with push_up past the bottom row
// and handles LF / CR / FF (clear screen) control codes.
// Optional feature macro: TERMINAL_BACKSPACE_EN -- when defined, 0x08 erases
// the cell left of the cursor; when undefined, 0x08 is an ordinary printable.
module terminal_writer #(
   parameter int         ROWS     = 16,
   parameter int         COLUMNS  = 40,
   parameter logic [7:0] BLANK_ID = 8'h00
) (
   input logic              clock,
   input logic              reset,
   terminal_writer_if.slave bus
);

   localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
   localparam logic [5:0] COL_LAST = 6'(COLUMNS - 1);

   localparam logic [7:0] CODE_BS = 8'h08;
   localparam logic [7:0] CODE_LF = 8'h0A;
   localparam logic [7:0] CODE_FF = 8'h0C;
   localparam logic [7:0] CODE_CR = 8'h0D;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EXEC   = 3'd1,
      S_WRITE  = 3'd2,
      S_SCROLL = 3'd3,
      S_CLEAR  = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_next_state;

   logic [3:0] r_row,    w_row_nxt;
   logic [5:0] r_col,    w_col_nxt;
   logic       r_we,     w_we_nxt;
   logic       r_push,   w_push_nxt;
   logic [7:0] r_wr_id,  w_wr_id_nxt;
   logic [3:0] r_wr_row, w_wr_row_nxt;
   logic [5:0] r_wr_col, w_wr_col_nxt;
   logic [7:0] r_cmd,    w_cmd_nxt;
   logic       r_pend,   w_pend_nxt;   // a scroll must follow the current write

   logic       w_ready;
   logic       w_accept;
   logic       w_is_bs;

   assign w_ready  = (r_state == S_IDLE) && !reset;
   assign w_accept = w_ready && bus.char_valid;

`ifdef TERMINAL_BACKSPACE_EN
   assign w_is_bs = (bus.char_in == CODE_BS);
`else
   assign w_is_bs = 1'b0;
`endif

   // State register: async reset returns the FSM to IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and next-value logic for cursor, write strobe and scroll strobe.
   always_comb begin
      w_next_state = r_state;
      w_row_nxt    = r_row;
      w_col_nxt    = r_col;
      w_we_nxt     = 1'b0;
      w_wr_id_nxt  = r_wr_id;
      w_wr_row_nxt = r_wr_row;
      w_wr_col_nxt = r_wr_col;
      w_cmd_nxt    = r_cmd;
      w_pend_nxt   = r_pend;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cmd_nxt = bus.char_in;
               if ((bus.char_in == CODE_LF) || (bus.char_in == CODE_CR) || w_is_bs) begin
                  w_next_state = S_EXEC;
               end else if (bus.char_in == CODE_FF) begin
                  // Clear walks the write address through every cell in raster order.
                  w_next_state = S_CLEAR;
                  w_we_nxt     = 1'b1;
                  w_wr_id_nxt  = BLANK_ID;
                  w_wr_row_nxt = 4'd0;
                  w_wr_col_nxt = 6'd0;
               end else begin
                  w_next_state = S_WRITE;
                  w_we_nxt     = 1'b1;
                  w_wr_id_nxt  = bus.char_in;
                  w_wr_row_nxt = r_row;
                  w_wr_col_nxt = r_col;
                  if (r_col == COL_LAST) begin
                     w_col_nxt = 6'd0;
                     if (r_row == ROW_LAST) begin
                        w_pend_nxt = 1'b1;
                     end else begin
                        w_row_nxt  = r_row + 4'd1;
                        w_pend_nxt = 1'b0;
                     end
                  end else begin
                     w_col_nxt  = r_col + 6'd1;
                     w_pend_nxt = 1'b0;
                  end
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end

         S_EXEC: begin
            case (r_cmd)
               CODE_LF: begin
                  w_col_nxt = 6'd0;
                  if (r_row == ROW_LAST) begin
                     w_next_state = S_SCROLL;
                  end else begin
                     w_row_nxt    = r_row + 4'd1;
                     w_next_state = S_IDLE;
                  end
               end
               CODE_CR: begin
                  w_col_nxt    = 6'd0;
                  w_next_state = S_IDLE;
               end
               CODE_BS: begin
                  // Only reachable when backspace is enabled; column 0 is a no-op.
                  if (r_col != 6'd0) begin
                     w_col_nxt    = r_col - 6'd1;
                     w_next_state = S_WRITE;
                     w_we_nxt     = 1'b1;
                     w_wr_id_nxt  = BLANK_ID;
                     w_wr_row_nxt = r_row;
                     w_wr_col_nxt = r_col - 6'd1;
                     w_pend_nxt   = 1'b0;
                  end else begin
                     w_next_state = S_IDLE;
                  end
               end
               default: begin
                  w_next_state = S_IDLE;
               end
            endcase
         end

         S_WRITE: begin
            w_pend_nxt = 1'b0;
            if (r_pend) begin
               w_next_state = S_SCROLL;
            end else begin
               w_next_state = S_IDLE;
            end
         end

         S_SCROLL: begin
            w_next_state = S_IDLE;
         end

         S_CLEAR: begin
            if ((r_wr_row == ROW_LAST) && (r_wr_col == COL_LAST)) begin
               w_next_state = S_IDLE;
               w_row_nxt    = 4'd0;
               w_col_nxt    = 6'd0;
            end else begin
               w_we_nxt    = 1'b1;
               w_wr_id_nxt = BLANK_ID;
               if (r_wr_col == COL_LAST) begin
                  w_wr_col_nxt = 6'd0;
                  w_wr_row_nxt = r_wr_row + 4'd1;
               end else begin
                  w_wr_col_nxt = r_wr_col + 6'd1;
               end
            end
         end

         default: begin
            w_next_state = S_IDLE;
         end
      endcase

      // push_up is high exactly while the FSM sits in SCROLL.
      w_push_nxt = (w_next_state == S_SCROLL);
   end

   // Datapath registers: cursor, latched command and registered plane outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_row    <= 4'd0;
         r_col    <= 6'd0;
         r_we     <= 1'b0;
         r_push   <= 1'b0;
         r_wr_id  <= 8'h00;
         r_wr_row <= 4'd0;
         r_wr_col <= 6'd0;
         r_cmd    <= 8'h00;
         r_pend   <= 1'b0;
      end else begin
         r_row    <= w_row_nxt;
         r_col    <= w_col_nxt;
         r_we     <= w_we_nxt;
         r_push   <= w_push_nxt;
         r_wr_id  <= w_wr_id_nxt;
         r_wr_row <= w_wr_row_nxt;
         r_wr_col <= w_wr_col_nxt;
         r_cmd    <= w_cmd_nxt;
         r_pend   <= w_pend_nxt;
      end
   end

   assign bus.char_ready      = w_ready;
   assign bus.we              = r_we;
   assign bus.push_up         = r_push;
   assign bus.wr_character_id = r_wr_id;
   assign bus.wr_row          = r_wr_row;
   assign bus.wr_column       = r_wr_col;
   assign bus.cursor_row      = r_row;
   assign bus.cursor_column   = r_col;

endmodule
